// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_pkg
//  Brief    : Shared encodings for the pipeline hazard scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Forward data source codes; FW_PC8 doubles as the bubble value.
    typedef enum logic [2:0] {
        FW_PC8 = 3'd0,
        FW_ALU = 3'd1,
        FW_EXT = 3'd2,
        FW_DM  = 3'd3,
        FW_MDU = 3'd4
    } fwsel_e;

    typedef enum logic [1:0] {
        MD_NONE = 2'd0,
        MD_MULT = 2'd1,
        MD_DIV  = 2'd2,
        MD_ACC  = 2'd3
    } md_kind_e;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

endpackage
`default_nettype wire

// File: rtl/hazard_match.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_match
//  Brief    : Youngest-stage priority finder for one register address.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_match #(
    parameter int N    = 3,
    parameter int BASE = 0,
    parameter int REGW = 5,
    parameter int TW   = 3,
    parameter int LW   = 2
) (
    input  logic [REGW-1:0]   i_addr,
    input  logic [N*REGW-1:0] i_dst,
    input  logic [N*TW-1:0]   i_tnew,
    output logic              o_hit,
    output logic [LW-1:0]     o_idx,
    output logic [TW-1:0]     o_tnew
);

    // Scan oldest to youngest so the youngest match is the last one written.
    always_comb begin
        o_hit  = 1'b0;
        o_idx  = '0;
        o_tnew = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_addr != '0 && i_dst[k*REGW +: REGW] == i_addr) begin
                o_hit  = 1'b1;
                o_idx  = LW'(BASE + k);
                o_tnew = i_tnew[k*TW +: TW];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_scoreboard
//  Brief    : Tnew/Tuse stall and forward-level scoreboard for an in-order
//             pipeline; HAZARD_MDU_EN adds a multiply/divide busy counter.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NSTAGE = 3,
    parameter int NSRC   = 2,
    parameter int REGW   = 5,
    parameter int TW     = 3,
    parameter int LW     = $clog2(NSTAGE + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        d_valid,
    input  logic [NSRC*REGW-1:0]        d_src,
    input  logic [NSRC*TW-1:0]          d_tuse,
    input  logic [REGW-1:0]             d_dst,
    input  logic [TW-1:0]               d_tnew,
    input  logic [2:0]                  d_fwsel,
    input  logic [1:0]                  d_md,
    input  logic                        flush,
    output logic                        stall,
    output logic [NSRC*LW-1:0]          d_fwlvl,
    output logic [NSTAGE*NSRC*LW-1:0]   s_fwlvl,
    output logic [NSTAGE*3-1:0]         s_fwsel
);

    logic [NSTAGE-1:0][REGW-1:0]      r_dst;
    logic [NSTAGE-1:0][TW-1:0]        r_tnew;
    logic [NSTAGE-1:0][2:0]           r_fwsel;
    logic [NSTAGE-1:0][NSRC*REGW-1:0] r_src;

    logic [NSRC-1:0] w_src_stall;
    logic            w_mdu_stall;
    logic            w_stall_raw;
    logic            w_accept;
    logic            w_unused_src;

    assign w_stall_raw  = (|w_src_stall) | w_mdu_stall;
    assign w_accept     = d_valid & ~w_stall_raw;
    assign stall        = ~flush & w_stall_raw;
    // Sources in the last stage have nobody older to forward from.
    assign w_unused_src = ^r_src[NSTAGE-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dst   <= '0;
            r_tnew  <= '0;
            r_fwsel <= '0;
            r_src   <= '0;
        end else if (flush) begin
            r_dst   <= '0;
            r_tnew  <= '0;
            r_fwsel <= '0;
            r_src   <= '0;
        end else begin
            for (int k = NSTAGE - 1; k > 0; k--) begin
                r_dst[k]   <= r_dst[k-1];
                r_tnew[k]  <= (r_tnew[k-1] != '0) ? r_tnew[k-1] - TW'(1) : '0;
                r_fwsel[k] <= r_fwsel[k-1];
                r_src[k]   <= r_src[k-1];
            end
            if (w_accept) begin
                r_dst[0]   <= d_dst;
                r_tnew[0]  <= d_tnew;
                r_fwsel[0] <= d_fwsel;
                r_src[0]   <= d_src;
            end else begin
                r_dst[0]   <= '0;
                r_tnew[0]  <= '0;
                r_fwsel[0] <= 3'(FW_PC8);
                r_src[0]   <= '0;
            end
        end
    end

    for (genvar i = 0; i < NSRC; i++) begin : g_dsrc
        logic          w_hit;
        logic [LW-1:0] w_idx;
        logic [TW-1:0] w_tn;

        hazard_match #(
            .N(NSTAGE), .BASE(0), .REGW(REGW), .TW(TW), .LW(LW)
        ) u_match (
            .i_addr (d_src[i*REGW +: REGW]),
            .i_dst  (r_dst),
            .i_tnew (r_tnew),
            .o_hit  (w_hit),
            .o_idx  (w_idx),
            .o_tnew (w_tn)
        );

        assign w_src_stall[i]      = w_hit && (w_tn > d_tuse[i*TW +: TW]);
        assign d_fwlvl[i*LW +: LW] = (w_hit && w_tn == '0) ? LW'(w_idx + 1'b1) : '0;
    end

    for (genvar s = 0; s < NSTAGE; s++) begin : g_stage
        assign s_fwsel[s*3 +: 3] = r_fwsel[s];

        if (s < NSTAGE - 1) begin : g_fwd
            for (genvar i = 0; i < NSRC; i++) begin : g_ssrc
                logic          w_hit;
                logic [LW-1:0] w_idx;
                logic [TW-1:0] w_tn;

                hazard_match #(
                    .N(NSTAGE - 1 - s), .BASE(s + 1), .REGW(REGW), .TW(TW), .LW(LW)
                ) u_match (
                    .i_addr (r_src[s][i*REGW +: REGW]),
                    .i_dst  (r_dst[NSTAGE-1:s+1]),
                    .i_tnew (r_tnew[NSTAGE-1:s+1]),
                    .o_hit  (w_hit),
                    .o_idx  (w_idx),
                    .o_tnew (w_tn)
                );

                assign s_fwlvl[(s*NSRC+i)*LW +: LW] =
                    (w_hit && w_tn == '0) ? LW'(w_idx + 1'b1) : '0;
            end
        end else begin : g_last
            assign s_fwlvl[s*NSRC*LW +: NSRC*LW] = '0;
        end
    end

`ifdef HAZARD_MDU_EN
    localparam int c_cnt_w = $clog2(DIV_LAT + 1);

    logic [c_cnt_w-1:0] r_mdu_cnt;
    logic [1:0]         r_md_start;

    // The counter starts when the mult/div leaves E, so E itself is one busy cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mdu_cnt  <= '0;
            r_md_start <= MD_NONE;
        end else if (flush) begin
            r_mdu_cnt  <= '0;
            r_md_start <= MD_NONE;
        end else begin
            r_md_start <= (w_accept && (d_md == MD_MULT || d_md == MD_DIV)) ? d_md : MD_NONE;
            if (r_md_start == MD_MULT)
                r_mdu_cnt <= c_cnt_w'(MULT_LAT);
            else if (r_md_start == MD_DIV)
                r_mdu_cnt <= c_cnt_w'(DIV_LAT);
            else if (r_mdu_cnt != '0)
                r_mdu_cnt <= r_mdu_cnt - c_cnt_w'(1);
        end
    end

    assign w_mdu_stall = (d_md != MD_NONE) && (r_mdu_cnt != '0 || r_md_start != MD_NONE);
`else
    logic w_unused_md;

    assign w_unused_md = ^d_md;
    assign w_mdu_stall = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_scoreboard
//  Brief    : Directed and random bench for hazard_scoreboard against an
//             instruction-list reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int NSTAGE = 3;
    localparam int NSRC   = 2;
    localparam int REGW   = 5;
    localparam int TW     = 3;
    localparam int LW     = 2;

`ifdef HAZARD_MDU_EN
    localparam int c_mult_stall = 1 + MULT_LAT;
    localparam int c_div_stall  = 1 + DIV_LAT;
`else
    localparam int c_mult_stall = 0;
    localparam int c_div_stall  = 0;
`endif

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      d_valid;
    logic [NSRC*REGW-1:0]      d_src;
    logic [NSRC*TW-1:0]        d_tuse;
    logic [REGW-1:0]           d_dst;
    logic [TW-1:0]             d_tnew;
    logic [2:0]                d_fwsel;
    logic [1:0]                d_md;
    logic                      flush;
    logic                      stall;
    logic [NSRC*LW-1:0]        d_fwlvl;
    logic [NSTAGE*NSRC*LW-1:0] s_fwlvl;
    logic [NSTAGE*3-1:0]       s_fwsel;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NSTAGE(NSTAGE), .NSRC(NSRC), .REGW(REGW), .TW(TW), .LW(LW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .d_valid (d_valid),
        .d_src   (d_src),
        .d_tuse  (d_tuse),
        .d_dst   (d_dst),
        .d_tnew  (d_tnew),
        .d_fwsel (d_fwsel),
        .d_md    (d_md),
        .flush   (flush),
        .stall   (stall),
        .d_fwlvl (d_fwlvl),
        .s_fwlvl (s_fwlvl),
        .s_fwsel (s_fwsel)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: list of in-flight instructions, index 0 = E.
    int m_dst   [NSTAGE];
    int m_tnew  [NSTAGE];
    int m_fwsel [NSTAGE];
    int m_src   [NSTAGE][NSRC];
    int free_at;  // first cycle at which the MDU accepts an access
    int cyc;

    logic                      seen_stall;
    logic [NSRC*LW-1:0]        seen_d;
    logic [NSTAGE*NSRC*LW-1:0] seen_s;
    logic [NSTAGE*3-1:0]       seen_f;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NSTAGE; k++) begin
            m_dst[k]   = 0;
            m_tnew[k]  = 0;
            m_fwsel[k] = 0;
            for (int i = 0; i < NSRC; i++) m_src[k][i] = 0;
        end
    endtask

    function automatic int youngest(input int a, input int from);
        if (a == 0) return -1;
        for (int k = from; k < NSTAGE; k++)
            if (m_dst[k] == a) return k;
        return -1;
    endfunction

    task automatic set_d(input logic v, input int s0, input int tu0, input int s1, input int tu1,
                         input int dst, input int tn, input int fw, input int md);
        d_valid = v;
        d_src   = {REGW'(s1), REGW'(s0)};
        d_tuse  = {TW'(tu1), TW'(tu0)};
        d_dst   = REGW'(dst);
        d_tnew  = TW'(tn);
        d_fwsel = 3'(fw);
        d_md    = 2'(md);
    endtask

    task automatic idle();
        set_d(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
        flush = 1'b0;
    endtask

    task automatic model_advance(input logic st);
        if (flush) begin
            model_clear();
            free_at = cyc + 1;
        end else begin
            for (int k = NSTAGE - 1; k > 0; k--) begin
                m_dst[k]   = m_dst[k-1];
                m_tnew[k]  = (m_tnew[k-1] > 0) ? m_tnew[k-1] - 1 : 0;
                m_fwsel[k] = m_fwsel[k-1];
                for (int i = 0; i < NSRC; i++) m_src[k][i] = m_src[k-1][i];
            end
            if (d_valid && !st) begin
                m_dst[0]   = int'(d_dst);
                m_tnew[0]  = int'(d_tnew);
                m_fwsel[0] = int'(d_fwsel);
                for (int i = 0; i < NSRC; i++) m_src[0][i] = int'(d_src[i*REGW +: REGW]);
                if (d_md == 2'd1) free_at = cyc + 2 + MULT_LAT;
                if (d_md == 2'd2) free_at = cyc + 2 + DIV_LAT;
            end else begin
                m_dst[0]   = 0;
                m_tnew[0]  = 0;
                m_fwsel[0] = 0;
                for (int i = 0; i < NSRC; i++) m_src[0][i] = 0;
            end
        end
    endtask

    // Called one time unit after a rising edge with D inputs already applied.
    task automatic tick(input string tag);
        logic                      e_stall;
        logic [NSRC*LW-1:0]        e_d;
        logic [NSTAGE*NSRC*LW-1:0] e_s;
        logic [NSTAGE*3-1:0]       e_f;
        int k;
        e_stall = 1'b0;
        e_d     = '0;
        e_s     = '0;
        e_f     = '0;
        for (int i = 0; i < NSRC; i++) begin
            k = youngest(int'(d_src[i*REGW +: REGW]), 0);
            if (k >= 0) begin
                if (m_tnew[k] > int'(d_tuse[i*TW +: TW])) e_stall = 1'b1;
                if (m_tnew[k] == 0) e_d[i*LW +: LW] = LW'(k + 1);
            end
        end
`ifdef HAZARD_MDU_EN
        if (d_md != 2'd0 && cyc < free_at) e_stall = 1'b1;
`endif
        if (flush) e_stall = 1'b0;
        for (int s = 0; s < NSTAGE; s++) begin
            e_f[s*3 +: 3] = 3'(m_fwsel[s]);
            if (s < NSTAGE - 1)
                for (int i = 0; i < NSRC; i++) begin
                    k = youngest(m_src[s][i], s + 1);
                    if (k >= 0 && m_tnew[k] == 0) e_s[(s*NSRC+i)*LW +: LW] = LW'(k + 1);
                end
        end
        @(negedge clk);
        seen_stall = stall;
        seen_d     = d_fwlvl;
        seen_s     = s_fwlvl;
        seen_f     = s_fwsel;
        check({tag, "_stall"},   stall,   e_stall);
        check({tag, "_d_fwlvl"}, d_fwlvl, e_d);
        check({tag, "_s_fwlvl"}, s_fwlvl, e_s);
        check({tag, "_s_fwsel"}, s_fwsel, e_f);
        @(posedge clk);
        model_advance(e_stall);
        cyc++;
        #1;
    endtask

    task automatic drain();
        idle();
        flush = 1'b1;
        tick("drain");
        flush = 1'b0;
    endtask

    task automatic count_md_stall(input int md, input string tag, input int exp);
        int n;
        drain();
        set_d(1'b1, 0, 0, 0, 0, 0, 0, 0, md);
        tick({tag, "_issue"});
        check({tag, "_issue_nostall"}, seen_stall, 1'b0);
        set_d(1'b1, 0, 0, 0, 0, 0, 0, 0, 3);
        n = 0;
        for (int c = 0; c < 20; c++) begin
            tick({tag, "_acc"});
            if (!seen_stall) break;
            n++;
        end
        check({tag, "_stall_cycles"}, 64'(n), 64'(exp));
    endtask

    function automatic int pick_reg();
        case ($urandom_range(0, 4))
            0:       return 0;
            1:       return 1;
            2:       return 2;
            3:       return 3;
            default: return 31;
        endcase
    endfunction

    task automatic random_traffic(input int n);
        for (int c = 0; c < n; c++) begin
            set_d($urandom_range(0, 3) != 0,
                  pick_reg(), $urandom_range(0, 3), pick_reg(), $urandom_range(0, 3),
                  pick_reg(), $urandom_range(0, 3), $urandom_range(0, 4),
                  ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0);
            flush = ($urandom_range(0, 29) == 0);
            tick("rnd");
        end
        idle();
    endtask

    initial begin
        cyc     = 0;
        free_at = 0;
        model_clear();
        idle();
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("rst_init_stall",   stall,   1'b0);
        check("rst_init_d_fwlvl", d_fwlvl, '0);
        check("rst_init_s_fwlvl", s_fwlvl, '0);
        check("rst_init_s_fwsel", s_fwsel, '0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk) #1;
        cyc++;

        // Load-use: load r1 (tnew 2) then consumer with tuse 1.
        drain();
        set_d(1'b1, 0, 0, 0, 0, 1, 2, FW_DM, 0);
        tick("lu_load");
        set_d(1'b1, 1, 1, 0, 0, 2, 1, FW_ALU, 0);
        tick("lu_c1");
        check("lu_stall_first", seen_stall, 1'b1);
        tick("lu_c2");
        check("lu_stall_second", seen_stall, 1'b0);
        idle();
        tick("lu_e");
        check("lu_e_src0_lvl", seen_s[LW-1:0], 2'd3);
        check("lu_w_fwsel", seen_f[8:6], FW_DM);

        // ALU result feeding a branch in D.
        drain();
        set_d(1'b1, 0, 0, 0, 0, 5, 1, FW_ALU, 0);
        tick("ab_alu");
        set_d(1'b1, 5, 0, 0, 0, 0, 0, 0, 0);
        tick("ab_b1");
        check("ab_stall_first", seen_stall, 1'b1);
        tick("ab_b2");
        check("ab_stall_second", seen_stall, 1'b0);
        check("ab_d_fwlvl", seen_d[LW-1:0], 2'd2);

        // jal then jr $31, then a register-0 source against a no-dst producer.
        drain();
        set_d(1'b1, 0, 0, 0, 0, 31, 0, FW_PC8, 0);
        tick("lk_jal");
        set_d(1'b1, 31, 0, 0, 0, 0, 0, 0, 0);
        tick("lk_jr");
        check("lk_stall", seen_stall, 1'b0);
        check("lk_d_fwlvl", seen_d[LW-1:0], 2'd1);
        set_d(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("lk_r0");
        check("lk_r0_stall", seen_stall, 1'b0);
        check("lk_r0_lvl", seen_d, '0);

        count_md_stall(1, "mult", c_mult_stall);
        count_md_stall(2, "div",  c_div_stall);

        // Flush while a load-use stall is pending.
        drain();
        set_d(1'b1, 0, 0, 0, 0, 1, 2, FW_DM, 0);
        tick("fl_load");
        set_d(1'b1, 1, 0, 0, 0, 0, 0, 0, 0);
        tick("fl_c1");
        check("fl_stall_before", seen_stall, 1'b1);
        flush = 1'b1;
        tick("fl_flush");
        check("fl_stall_drop", seen_stall, 1'b0);
        flush = 1'b0;
        tick("fl_after");
        check("fl_after_stall", seen_stall, 1'b0);
        check("fl_after_fwsel", seen_f, '0);

        random_traffic(400);

        // Reset in the middle of a pending load-use stall.
        drain();
        set_d(1'b1, 0, 0, 0, 0, 1, 2, FW_DM, 0);
        tick("mr_load");
        set_d(1'b1, 1, 0, 0, 0, 0, 0, 0, 0);
        #2;
        check("mr_pre_stall", stall, 1'b1);
        reset = 1'b0;
        #1;
        check("mr_stall",   stall,   1'b0);
        check("mr_d_fwlvl", d_fwlvl, '0);
        check("mr_s_fwlvl", s_fwlvl, '0);
        check("mr_s_fwsel", s_fwsel, '0);
        model_clear();
        free_at = 0;
        idle();
        @(negedge clk) reset = 1'b1;
        @(posedge clk) #1;
        cyc++;
        set_d(1'b1, 1, 0, 0, 0, 0, 0, 0, 0);
        tick("mr_post");
        check("mr_load_gone", seen_stall, 1'b0);

        random_traffic(200);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
